// File: rtl/v2f_alu_sched_if.sv
// Bundle between the requesting cells, the scheduler and the shared arithmetic unit.
// resp_dz exists only when V2F_ALU_SCHED_DIVZERO_EN is defined.
interface v2f_alu_sched_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32,
  parameter int OPW   = 4
);
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*OPW-1:0]   req_op;
  logic [N_REQ*WIDTH-1:0] req_a;
  logic [N_REQ*WIDTH-1:0] req_b;
  logic                   alu_issue;
  logic [OPW-1:0]         alu_op;
  logic [WIDTH-1:0]       alu_a;
  logic [WIDTH-1:0]       alu_b;
  logic [WIDTH-1:0]       alu_y;
  logic [N_REQ-1:0]       resp_valid;
  logic [WIDTH-1:0]       resp_y;
  logic                   busy;
`ifdef V2F_ALU_SCHED_DIVZERO_EN
  logic                   resp_dz;

  modport master (
    output req_valid, req_op, req_a, req_b, alu_y,
    input  req_ready, alu_issue, alu_op, alu_a, alu_b, resp_valid, resp_y, busy, resp_dz
  );
  modport slave (
    input  req_valid, req_op, req_a, req_b, alu_y,
    output req_ready, alu_issue, alu_op, alu_a, alu_b, resp_valid, resp_y, busy, resp_dz
  );
`else
  modport master (
    output req_valid, req_op, req_a, req_b, alu_y,
    input  req_ready, alu_issue, alu_op, alu_a, alu_b, resp_valid, resp_y, busy
  );
  modport slave (
    input  req_valid, req_op, req_a, req_b, alu_y,
    output req_ready, alu_issue, alu_op, alu_a, alu_b, resp_valid, resp_y, busy
  );
`endif
endinterface

// File: rtl/v2f_alu_sched.sv
// Round-robin scheduler time-sharing one pipelined ALU among N_REQ requesters.
// Optional macro V2F_ALU_SCHED_DIVZERO_EN: div/mod by zero bypasses the unit and returns 0 with resp_dz.
module v2f_alu_sched #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32,
  parameter int LAT   = 2,
  parameter int OPW   = 4
) (
  input logic            clk,
  input logic            rst,
  v2f_alu_sched_if.slave bus
);
  localparam int IDW = $clog2(N_REQ);

  logic [IDW-1:0]   ptr_q, ptr_d;
  logic             grantFound;
  logic [IDW-1:0]   grantId;
  logic             xfer;
  logic [OPW-1:0]   grantOp;
  logic [WIDTH-1:0] grantA, grantB;
  logic             grantDz;

  logic             s0Vld_q, s0Vld_d;
  logic             s0Dz_q, s0Dz_d;
  logic [IDW-1:0]   s0Id_q, s0Id_d;
  logic [OPW-1:0]   op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;

  logic [LAT-1:0]   tagVld_q, tagVld_d;
  logic [LAT-1:0]   tagDz_q, tagDz_d;
  logic [IDW-1:0]   tagId_q [LAT];
  logic [IDW-1:0]   tagId_d [LAT];

  logic [N_REQ-1:0] respVld_q, respVld_d;
  logic [WIDTH-1:0] respY_q, respY_d;
`ifdef V2F_ALU_SCHED_DIVZERO_EN
  logic             respDz_q, respDz_d;
`endif

  // Search from ptr upward first, then wrap to the indices below ptr.
  always_comb begin
    grantFound = 1'b0;
    grantId    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!grantFound && bus.req_valid[i] && (i >= int'(ptr_q))) begin
        grantFound = 1'b1;
        grantId    = IDW'(i);
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!grantFound && bus.req_valid[i] && (i < int'(ptr_q))) begin
        grantFound = 1'b1;
        grantId    = IDW'(i);
      end
    end
  end

  assign xfer = grantFound & ~rst;

  always_comb begin
    bus.req_ready = '0;
    grantOp       = '0;
    grantA        = '0;
    grantB        = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (IDW'(i) == grantId) begin
        bus.req_ready[i] = xfer;
        grantOp          = bus.req_op[i*OPW +: OPW];
        grantA           = bus.req_a[i*WIDTH +: WIDTH];
        grantB           = bus.req_b[i*WIDTH +: WIDTH];
      end
    end
  end

`ifdef V2F_ALU_SCHED_DIVZERO_EN
  assign grantDz = ((grantOp == OPW'(3)) || (grantOp == OPW'(4))) && (grantB == '0);
`else
  assign grantDz = 1'b0;
`endif

  always_comb begin
    ptr_d   = ptr_q;
    s0Vld_d = xfer;
    s0Dz_d  = 1'b0;
    s0Id_d  = grantId;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    if (xfer) begin
      ptr_d  = (int'(grantId) == N_REQ - 1) ? '0 : grantId + IDW'(1);
      s0Dz_d = grantDz;
      // Bypassed ops leave the unit's operands untouched.
      if (!grantDz) begin
        op_d = grantOp;
        a_d  = grantA;
        b_d  = grantB;
      end
    end

    tagVld_d[0] = s0Vld_q;
    tagDz_d[0]  = s0Dz_q;
    tagId_d[0]  = s0Id_q;
    for (int k = 1; k < LAT; k++) begin
      tagVld_d[k] = tagVld_q[k-1];
      tagDz_d[k]  = tagDz_q[k-1];
      tagId_d[k]  = tagId_q[k-1];
    end

    // The deepest tag lines up with alu_y; capture it into the response register.
    respVld_d = '0;
    respY_d   = respY_q;
    for (int i = 0; i < N_REQ; i++) begin
      respVld_d[i] = tagVld_q[LAT-1] && (tagId_q[LAT-1] == IDW'(i));
    end
    if (tagVld_q[LAT-1]) begin
      respY_d = tagDz_q[LAT-1] ? '0 : bus.alu_y;
    end
`ifdef V2F_ALU_SCHED_DIVZERO_EN
    respDz_d = tagVld_q[LAT-1] & tagDz_q[LAT-1];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= '0;
      s0Vld_q   <= 1'b0;
      s0Dz_q    <= 1'b0;
      s0Id_q    <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      tagVld_q  <= '0;
      tagDz_q   <= '0;
      for (int k = 0; k < LAT; k++) begin
        tagId_q[k] <= '0;
      end
      respVld_q <= '0;
      respY_q   <= '0;
`ifdef V2F_ALU_SCHED_DIVZERO_EN
      respDz_q  <= 1'b0;
`endif
    end else begin
      ptr_q     <= ptr_d;
      s0Vld_q   <= s0Vld_d;
      s0Dz_q    <= s0Dz_d;
      s0Id_q    <= s0Id_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      tagVld_q  <= tagVld_d;
      tagDz_q   <= tagDz_d;
      for (int k = 0; k < LAT; k++) begin
        tagId_q[k] <= tagId_d[k];
      end
      respVld_q <= respVld_d;
      respY_q   <= respY_d;
`ifdef V2F_ALU_SCHED_DIVZERO_EN
      respDz_q  <= respDz_d;
`endif
    end
  end

  assign bus.alu_issue  = s0Vld_q & ~s0Dz_q;
  assign bus.alu_op     = op_q;
  assign bus.alu_a      = a_q;
  assign bus.alu_b      = b_q;
  assign bus.resp_valid = respVld_q;
  assign bus.resp_y     = respY_q;
  assign bus.busy       = s0Vld_q | (|tagVld_q);
`ifdef V2F_ALU_SCHED_DIVZERO_EN
  assign bus.resp_dz    = respDz_q;
`endif
endmodule

// File: tb/tb_v2f_alu_sched.sv
// Bench for v2f_alu_sched: directed vector table, reset and corner sequences, then random traffic
// checked against a queue-based reference model; the shared ALU is a behavioural stand-in.
module tb_v2f_alu_sched;
  localparam int NR  = 4;
  localparam int W   = 32;
  localparam int LAT = 2;
  localparam int OW  = 4;

  typedef struct {
    int          due;
    int          id;
    logic [W-1:0] y;
    bit          dz;
  } resp_t;

  typedef struct {
    logic [NR-1:0] valid;
    int            base;
    logic [NR-1:0] expReady;
  } vec_t;

  logic clk;
  logic rst;
  v2f_alu_sched_if #(.N_REQ(NR), .WIDTH(W), .OPW(OW)) bus ();

  v2f_alu_sched #(.N_REQ(NR), .WIDTH(W), .LAT(LAT), .OPW(OW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  int mptr  = 0;
  int cyc   = 0;
  resp_t q[$];
  logic [OW-1:0] reqOp [NR];
  logic [W-1:0]  reqA  [NR];
  logic [W-1:0]  reqB  [NR];
  vec_t tab [18];
  logic [W-1:0] dl [LAT];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] tbAlu(input logic [OW-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a * b;
      4'd3:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd4:    return (b == 0) ? a : a % b;
      4'd6:    return a & b;
      4'd7:    return a | b;
      4'd8:    return a ^ b;
      4'd9:    return a << b[4:0];
      4'd10:   return a >> b[4:0];
      4'd11:   return W'($signed(a) >>> b[4:0]);
      default: return a ^ ~b ^ {28'd0, op};
    endcase
  endfunction

  // Stand-in shared unit: result appears LAT cycles after the operands were issued.
  always @(posedge clk) begin
    dl[0] <= tbAlu(bus.alu_op, bus.alu_a, bus.alu_b);
    for (int k = 1; k < LAT; k++) dl[k] <= dl[k-1];
  end
  assign bus.alu_y = dl[LAT-1];

  function automatic int modelGrant(input logic [NR-1:0] v, input int p);
    for (int k = 0; k < NR; k++) begin
      int idx;
      idx = (p + k) % NR;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s at cycle %0d: got %0h want %0h", name, cyc, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [NR-1:0] v);
    bus.req_valid = v;
    for (int i = 0; i < NR; i++) begin
      bus.req_op[i*OW +: OW] = reqOp[i];
      bus.req_a[i*W +: W]    = reqA[i];
      bus.req_b[i*W +: W]    = reqB[i];
    end
  endtask

  task automatic setOperands(input int base);
    for (int i = 0; i < NR; i++) begin
      reqOp[i] = OW'((base + i) % 12);
      reqA[i]  = W'(base * 100 + i);
      reqB[i]  = W'(base + i + 1);
    end
  endtask

  // One clock cycle: drive, check grant, advance the model, then check issue/response/busy.
  task automatic step(input logic [NR-1:0] v, input bit useTab, input logic [NR-1:0] tabReady);
    int            g;
    logic [NR-1:0] expRdy;
    resp_t         e;
    bit            dz;
    bit            issExp;
    logic [OW-1:0] eOp;
    logic [W-1:0]  eA;
    logic [W-1:0]  eB;
    applyStimulus(v);
    #1;
    g = modelGrant(v, mptr);
    expRdy = '0;
    if (g >= 0) expRdy[g] = 1'b1;
    checkOutput("req_ready", W'(bus.req_ready), W'(expRdy));
    if (useTab) checkOutput("table_ready", W'(bus.req_ready), W'(tabReady));
    eOp = '0; eA = '0; eB = '0;
    if (g >= 0) begin
      eOp = reqOp[g]; eA = reqA[g]; eB = reqB[g];
    end
    @(posedge clk);
    cyc++;
    issExp = 1'b0;
    if (g >= 0) begin
      dz = 1'b0;
`ifdef V2F_ALU_SCHED_DIVZERO_EN
      dz = ((eOp == 4'd3) || (eOp == 4'd4)) && (eB == 0);
`endif
      e.due = cyc + LAT + 1;
      e.id  = g;
      e.dz  = dz;
      e.y   = dz ? '0 : tbAlu(eOp, eA, eB);
      q.push_back(e);
      mptr   = (g + 1) % NR;
      issExp = !dz;
    end
    @(negedge clk);
    checkOutput("alu_issue", W'(bus.alu_issue), W'(issExp));
    if (issExp) begin
      checkOutput("alu_op", W'(bus.alu_op), W'(eOp));
      checkOutput("alu_a", bus.alu_a, eA);
      checkOutput("alu_b", bus.alu_b, eB);
    end
    if (q.size() > 0 && q[0].due == cyc) begin
      checkOutput("resp_valid", W'(bus.resp_valid), W'(1) << q[0].id);
      checkOutput("resp_y", bus.resp_y, q[0].y);
`ifdef V2F_ALU_SCHED_DIVZERO_EN
      checkOutput("resp_dz", W'(bus.resp_dz), W'(q[0].dz));
`endif
      void'(q.pop_front());
    end else begin
      checkOutput("resp_valid_idle", W'(bus.resp_valid), '0);
    end
    checkOutput("busy", W'(bus.busy), W'(q.size() > 0));
  endtask

  task automatic doReset(input logic [NR-1:0] v);
    rst = 1'b1;
    applyStimulus(v);
    #1;
    checkOutput("rst_req_ready", W'(bus.req_ready), '0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_alu_issue", W'(bus.alu_issue), '0);
    checkOutput("rst_alu_op", W'(bus.alu_op), '0);
    checkOutput("rst_alu_a", bus.alu_a, '0);
    checkOutput("rst_alu_b", bus.alu_b, '0);
    checkOutput("rst_resp_valid", W'(bus.resp_valid), '0);
    checkOutput("rst_resp_y", bus.resp_y, '0);
    checkOutput("rst_busy", W'(bus.busy), '0);
`ifdef V2F_ALU_SCHED_DIVZERO_EN
    checkOutput("rst_resp_dz", W'(bus.resp_dz), '0);
`endif
    rst  = 1'b0;
    mptr = 0;
    cyc  = 0;
    q.delete();
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < NR; i++) begin
      reqOp[i] = '0; reqA[i] = '0; reqB[i] = '0;
    end
    tab[0]  = '{4'b1111, 1,  4'b0001};
    tab[1]  = '{4'b1111, 2,  4'b0010};
    tab[2]  = '{4'b1111, 3,  4'b0100};
    tab[3]  = '{4'b1111, 4,  4'b1000};
    tab[4]  = '{4'b1111, 5,  4'b0001};
    tab[5]  = '{4'b0100, 6,  4'b0100};
    tab[6]  = '{4'b0010, 7,  4'b0010};
    tab[7]  = '{4'b1001, 8,  4'b1000};
    tab[8]  = '{4'b1001, 9,  4'b0001};
    tab[9]  = '{4'b0000, 10, 4'b0000};
    tab[10] = '{4'b0100, 11, 4'b0100};
    tab[11] = '{4'b0100, 12, 4'b0100};
    tab[12] = '{4'b0100, 13, 4'b0100};
    tab[13] = '{4'b0100, 14, 4'b0100};
    tab[14] = '{4'b0000, 15, 4'b0000};
    tab[15] = '{4'b0000, 16, 4'b0000};
    tab[16] = '{4'b0000, 17, 4'b0000};
    tab[17] = '{4'b0000, 18, 4'b0000};

    doReset(4'b0000);

    // Single add from requester 1: 5 + 7 returned on resp_valid[1] three cycles after accept.
    reqOp[1] = 4'd0; reqA[1] = 32'd5; reqB[1] = 32'd7;
    step(4'b0010, 1'b1, 4'b0010);
    repeat (4) step(4'b0000, 1'b0, 4'b0000);

    doReset(4'b0000);
    for (int r = 0; r < 18; r++) begin
      setOperands(tab[r].base);
      step(tab[r].valid, 1'b1, tab[r].expReady);
    end

    // Two ops in flight, reset before either response; nothing may come back.
    setOperands(40);
    step(4'b0011, 1'b0, 4'b0000);
    step(4'b0011, 1'b0, 4'b0000);
    doReset(4'b1111);
    repeat (5) step(4'b0000, 1'b0, 4'b0000);

`ifdef V2F_ALU_SCHED_DIVZERO_EN
    reqOp[0] = 4'd3; reqA[0] = 32'd9; reqB[0] = 32'd0;
    step(4'b0001, 1'b1, 4'b0001);
    repeat (4) step(4'b0000, 1'b0, 4'b0000);
    reqB[0] = 32'd3;
    step(4'b0001, 1'b1, 4'b0001);
    repeat (4) step(4'b0000, 1'b0, 4'b0000);
`endif

    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NR; i++) begin
        reqOp[i] = OW'($urandom_range(0, 15));
        reqA[i]  = $urandom;
        reqB[i]  = ($urandom_range(0, 3) == 0) ? '0 : $urandom;
      end
      step(NR'($urandom), 1'b0, 4'b0000);
    end
    repeat (5) step(4'b0000, 1'b0, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
